// File: rtl/gesture_queue_sequencer.sv
// ---------------------------------------------------------------------------
// gesture_queue_sequencer
//
// Queues gesture codes captured on rising edges of a debounced enqueue level
// and plays them back in order. Each gesture selects a per-servo pulse-width
// pose that is held for HOLD_CYCLES cycles. All servo PWM channels share one
// frame counter. A channel's width only changes on the last cycle of a frame,
// so every emitted pulse is a complete, unglitched frame.
//
// Optional build macro:
//   SLEW_LIMIT_EN - when defined, each frame boundary moves every active
//                   width toward its target by at most SLEW_STEP. When
//                   undefined, the width jumps straight to the target at the
//                   next frame boundary.
//
// Ports:
//   CLOCK_50        in   system clock, rising edge
//   reset           in   synchronous active-high reset; flushes the queue
//   gesture_in      in   gesture code, captured on an enqueue edge
//   enq             in   enqueue request level; one push per 0->1 transition
//   pwm             out  registered servo PWM outputs, bit i = servo i
//   busy            out  high while a gesture is loaded/held
//   current_gesture out  code of the gesture loaded/held (persists when idle)
//   queue_count     out  FIFO occupancy
//   queue_full      out  queue_count == QUEUE_DEPTH
//   overflow        out  one-cycle pulse when an enqueue edge is dropped
//   dbg_state       out  sequencer FSM state (0 idle, 1 load, 2 hold)
// ---------------------------------------------------------------------------
module gesture_queue_sequencer #(
    parameter int NUM_SERVOS  = 5,
    parameter int GESTURE_W   = 8,
    parameter int QUEUE_DEPTH = 8,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int PWM_PERIOD  = 1_000_000,
    parameter int PULSE_MIN   = 50_000,
    parameter int PULSE_MAX   = 100_000,
    parameter int SLEW_STEP   = 1_000
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic [GESTURE_W-1:0]           gesture_in,
    input  logic                           enq,
    output logic [NUM_SERVOS-1:0]          pwm,
    output logic                           busy,
    output logic [GESTURE_W-1:0]           current_gesture,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           queue_full,
    output logic                           overflow,
    output logic [1:0]                     dbg_state
);

    localparam int PW = $clog2(PWM_PERIOD);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int QW = AW + 1;

    localparam logic [PW-1:0] W_MIN       = PW'(PULSE_MIN);
    localparam logic [PW-1:0] W_MAX       = PW'(PULSE_MAX);
    localparam logic [PW-1:0] W_NEUTRAL   = PW'((PULSE_MIN + PULSE_MAX) / 2);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PWM_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
    localparam logic [QW-1:0] DEPTH_VAL   = QW'(QUEUE_DEPTH);

    // Reject parameter sets that would make a width reach or exceed the frame
    // or break the power-of-two pointer wrap of the queue.
    if (NUM_SERVOS < 1 || NUM_SERVOS > 16 ||
        QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 ||
        HOLD_CYCLES < 1 || PWM_PERIOD < 2 ||
        PULSE_MIN < 1 || PULSE_MIN > PULSE_MAX || PULSE_MAX >= PWM_PERIOD ||
        SLEW_STEP < 1 || SLEW_STEP >= PWM_PERIOD) begin : g_bad_params
        $error("gesture_queue_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Enqueue handshake: a push is requested on the cycle enq is 1 and was 0
    // on the previous cycle. It is accepted when the queue is not full, or
    // when the sequencer pops in that same cycle; otherwise it is dropped and
    // overflow pulses on the following cycle. There is no back-pressure.
    // -----------------------------------------------------------------------
    logic                 enq_q;
    logic                 enq_edge;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 overflow_q;
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [QW-1:0]        count_q;
    logic [QW-1:0]        count_d;
    logic [GESTURE_W-1:0] mem_q [QUEUE_DEPTH];
    logic [GESTURE_W-1:0] head;

    // Sequencer state
    state_t               state_q;
    logic                 busy_q;
    logic [GESTURE_W-1:0] gesture_q;
    logic [GESTURE_W-1:0] pending_q;
    logic [HW-1:0]        hold_cnt_q;
    logic                 hold_done;
    logic [PW-1:0]        target_q [NUM_SERVOS];

    // PWM state
    logic [PW-1:0]         cnt_q;
    logic [PW-1:0]         active_q [NUM_SERVOS];
    logic [NUM_SERVOS-1:0] pwm_q;

    assign enq_edge   = enq & ~enq_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_VAL);
    assign head       = mem_q[rd_ptr_q];
    assign hold_done  = (state_q == S_HOLD) && (hold_cnt_q == HOLD_LAST);
    // The sequencer takes the head whenever it is idle or finishing a hold.
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || hold_done);
    assign push       = enq_edge && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + QW'(1);
            2'b01:   count_d = count_q - QW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            enq_q      <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            enq_q      <= enq;
            overflow_q <= enq_edge && fifo_full && !pop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: occupancy is governed by count_q alone.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= gesture_in;
    end

    // Pose map: 1 rock (all closed), 2 paper (all open), 3 scissors
    // (servos 1 and 2 open, rest closed); anything else is neutral.
    function automatic logic [PW-1:0] pose_width(input logic [GESTURE_W-1:0] code,
                                                 input int servo);
        if (code == GESTURE_W'(1))      return W_MAX;
        else if (code == GESTURE_W'(2)) return W_MIN;
        else if (code == GESTURE_W'(3)) return (servo == 1 || servo == 2) ? W_MIN : W_MAX;
        else                            return W_NEUTRAL;
    endfunction

    // -----------------------------------------------------------------------
    // Sequencer FSM. The head is captured into pending_q on the pop cycle and
    // becomes visible (busy, current_gesture, targets) after the LOAD cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            gesture_q  <= '0;
            pending_q  <= '0;
            hold_cnt_q <= '0;
            for (int i = 0; i < NUM_SERVOS; i++) target_q[i] <= W_NEUTRAL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        pending_q <= head;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    gesture_q  <= pending_q;
                    busy_q     <= 1'b1;
                    hold_cnt_q <= '0;
                    for (int i = 0; i < NUM_SERVOS; i++) target_q[i] <= pose_width(pending_q, i);
                    state_q    <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_done) begin
                        if (pop) begin
                            pending_q <= head;
                            state_q   <= S_LOAD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef SLEW_LIMIT_EN
    localparam logic [PW-1:0] W_STEP = PW'(SLEW_STEP);

    // Move cur toward tgt by at most W_STEP, landing exactly on tgt when close.
    function automatic logic [PW-1:0] slew_toward(input logic [PW-1:0] cur,
                                                  input logic [PW-1:0] tgt);
        if (tgt > cur)      return ((tgt - cur) <= W_STEP) ? tgt : cur + W_STEP;
        else if (cur > tgt) return ((cur - tgt) <= W_STEP) ? tgt : cur - W_STEP;
        else                return cur;
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Shared frame counter and per-servo comparators. Widths only update on
    // the last count of a frame, so the comparison never sees a mid-frame
    // width change.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= '0;
            for (int i = 0; i < NUM_SERVOS; i++) active_q[i] <= W_NEUTRAL;
        end else begin
            cnt_q <= (cnt_q == PERIOD_LAST) ? '0 : cnt_q + PW'(1);
            for (int i = 0; i < NUM_SERVOS; i++) begin
                pwm_q[i] <= (cnt_q < active_q[i]);
                if (cnt_q == PERIOD_LAST) begin
`ifdef SLEW_LIMIT_EN
                    active_q[i] <= slew_toward(active_q[i], target_q[i]);
`else
                    active_q[i] <= target_q[i];
`endif
                end
            end
        end
    end

    assign pwm             = pwm_q;
    assign busy            = busy_q;
    assign current_gesture = gesture_q;
    assign queue_count     = count_q;
    assign queue_full      = fifo_full;
    assign overflow        = overflow_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_gesture_queue_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gesture_queue_sequencer
//
// Directed bench for gesture_queue_sequencer with small timing parameters.
// A negedge monitor pairs every gesture load with the expected-code queue
// and checks load spacing and busy span lengths; the main sequence drives
// enqueue pulses and checks occupancy, overflow, latency and PWM widths.
// Build with +define+SLEW_LIMIT_EN to exercise the slewed width sequence.
// ---------------------------------------------------------------------------
module tb_gesture_queue_sequencer;

    localparam int NS     = 5;
    localparam int GW     = 8;
    localparam int QD     = 4;
    localparam int HOLD   = 100;
    localparam int PERIOD = 200;
    localparam int PMIN   = 10;
    localparam int PMAX   = 20;
    localparam int NEUT   = 15;
    localparam int SETTLE = 6 * PERIOD;

    logic                 clk;
    logic                 reset;
    logic [GW-1:0]        gesture_in;
    logic                 enq;
    logic [NS-1:0]        pwm;
    logic                 busy;
    logic [GW-1:0]        current_gesture;
    logic [$clog2(QD):0]  queue_count;
    logic                 queue_full;
    logic                 overflow;
    logic [1:0]           dbg_state;

    gesture_queue_sequencer #(
        .NUM_SERVOS  (NS),
        .GESTURE_W   (GW),
        .QUEUE_DEPTH (QD),
        .HOLD_CYCLES (HOLD),
        .PWM_PERIOD  (PERIOD),
        .PULSE_MIN   (PMIN),
        .PULSE_MAX   (PMAX),
        .SLEW_STEP   (2)
    ) dut (
        .CLOCK_50        (clk),
        .reset           (reset),
        .gesture_in      (gesture_in),
        .enq             (enq),
        .pwm             (pwm),
        .busy            (busy),
        .current_gesture (current_gesture),
        .queue_count     (queue_count),
        .queue_full      (queue_full),
        .overflow        (overflow),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [GW-1:0] exp_q[$];
    int          hi_cnt[NS];
    logic        last_ovf;

    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic        prev_busy = 1'b0;
    logic [GW-1:0] prev_cg = '0;
    int          last_load = 0;
    int          rise_cyc = 0;
    int          span_loads = 0;
    int          n_loads = 0;
    int          ovf_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Every load is recognised by busy rising or the code changing while busy.
    always @(negedge clk) begin
        cyc++;
        if (overflow) ovf_cnt++;
        if (mon_en) begin
            if (busy && (!prev_busy || current_gesture != prev_cg)) begin
                n_loads++;
                if (exp_q.size() > 0)
                    check("load_code", 32'(current_gesture), 32'(exp_q.pop_front()));
                else
                    check("load_code_unexpected", 32'(current_gesture), 32'hFFFF_FFFF);
                if (prev_busy) begin
                    check("load_interval", 32'(cyc - last_load), 32'(HOLD + 1));
                    span_loads++;
                end else begin
                    rise_cyc   = cyc;
                    span_loads = 1;
                end
                last_load = cyc;
            end
            if (!busy && prev_busy)
                check("busy_span", 32'(cyc - rise_cyc), 32'(span_loads * (HOLD + 1) - 1));
        end
        prev_busy = busy;
        prev_cg   = current_gesture;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enq_pulse(input logic [GW-1:0] code);
        gesture_in = code;
        enq        = 1'b1;
        @(negedge clk);
        last_ovf   = overflow;
        enq        = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_busy(input logic val, input int budget, input string tag);
        int k = 0;
        while (busy !== val && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'(val));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((busy || queue_count != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic measure_window();
        for (int i = 0; i < NS; i++) hi_cnt[i] = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) if (pwm[i]) hi_cnt[i]++;
        end
    endtask

    task automatic check_widths(input string tag, input int w0, input int w1,
                                input int w2, input int w3, input int w4);
        int exp_w[NS];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3; exp_w[4] = w4;
        measure_window();
        for (int i = 0; i < NS; i++)
            check($sformatf("%s_servo%0d", tag, i), 32'(hi_cnt[i]), 32'(exp_w[i]));
    endtask

    // Length of the next complete high pulse on servo 0.
    task automatic pulse_len(output int len);
        int   k = 0;
        logic prev = pwm[0];
        while (k < 2 * PERIOD) begin
            @(negedge clk);
            k++;
            if (pwm[0] && !prev) break;
            prev = pwm[0];
        end
        len = 0;
        while (pwm[0] && len < PERIOD) begin
            len++;
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp_pulse[3];
        int plen;
        int ovf_before;
        int loads_before;
        int peak;
        int max_busy;

`ifdef SLEW_LIMIT_EN
        exp_pulse[0] = 17; exp_pulse[1] = 19; exp_pulse[2] = 20;
`else
        exp_pulse[0] = 20; exp_pulse[1] = 20; exp_pulse[2] = 20;
`endif

        reset      = 1'b1;
        enq        = 1'b0;
        gesture_in = '0;
        last_ovf   = 1'b0;

        // 1. reset state and neutral frames
        tick(3);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gesture", 32'(current_gesture), 32'd0);
        check("rst_count", 32'(queue_count), 32'd0);
        check("rst_full", 32'(queue_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        check_widths("neutral", NEUT, NEUT, NEUT, NEUT, NEUT);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_count", 32'(queue_count), 32'd0);
        mon_en = 1'b1;

        // 2. enqueue latency and width transition for rock
        exp_q.push_back(8'd1);
        gesture_in = 8'd1;
        enq        = 1'b1;
        @(negedge clk);
        check("lat_count_t1", 32'(queue_count), 32'd1);
        check("lat_busy_t1", 32'(busy), 32'd0);
        enq = 1'b0;
        @(negedge clk);
        check("lat_busy_t2", 32'(busy), 32'd0);
        check("lat_count_t2", 32'(queue_count), 32'd0);
        @(negedge clk);
        check("lat_busy_t3", 32'(busy), 32'd1);
        check("lat_gesture_t3", 32'(current_gesture), 32'd1);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            pulse_len(plen);
            check($sformatf("rock_pulse%0d", p), 32'(plen), 32'(exp_pulse[p]));
        end
        wait_idle(1000, "rock_idle");
        check_widths("rock", PMAX, PMAX, PMAX, PMAX, PMAX);

        // 3. three gestures 50 cycles apart play back in order
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd2);
        exp_q.push_back(8'd3);
        enq_pulse(8'd1);
        tick(48);
        enq_pulse(8'd2);
        tick(48);
        enq_pulse(8'd3);
        wait_idle(2000, "chain_idle");
        check("chain_drained", 32'(exp_q.size()), 32'd0);
        tick(SETTLE);
        check_widths("scissors", PMAX, PMIN, PMIN, PMAX, PMAX);

        // 4. fill a depth-4 queue during a hold, fifth edge dropped
        ovf_before = ovf_cnt;
        exp_q.push_back(8'd1);
        enq_pulse(8'd1);
        wait_busy(1'b1, 10, "fill_busy");
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(GW'(k + 1));
            enq_pulse(GW'(k + 1));
            check($sformatf("fill_count%0d", k), 32'(queue_count), 32'(k));
            check($sformatf("fill_full%0d", k), 32'(queue_full), 32'(k == QD));
            check($sformatf("fill_ovf%0d", k), 32'(last_ovf), 32'd0);
        end
        enq_pulse(8'd6);
        check("drop_ovf", 32'(last_ovf), 32'd1);
        check("drop_ovf_clear", 32'(overflow), 32'd0);
        check("drop_count", 32'(queue_count), 32'd4);
        check("drop_full", 32'(queue_full), 32'd1);
        wait_idle(1000, "fill_idle");
        check("fill_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_pulses", 32'(ovf_cnt - ovf_before), 32'd1);
        tick(SETTLE);
        check_widths("other_code", NEUT, NEUT, NEUT, NEUT, NEUT);

        // 5. held-high enq gives a single push
        loads_before = n_loads;
        peak = 0;
        exp_q.push_back(8'd2);
        gesture_in = 8'd2;
        enq        = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (int'(queue_count) > peak) peak = int'(queue_count);
        end
        enq = 1'b0;
        wait_idle(1000, "held_idle");
        check("held_peak", 32'(peak), 32'd1);
        check("held_loads", 32'(n_loads - loads_before), 32'd1);
        check("held_drained", 32'(exp_q.size()), 32'd0);
        tick(SETTLE);
        check_widths("paper", PMIN, PMIN, PMIN, PMIN, PMIN);

        // 6. reset during a hold with two gestures queued
        exp_q.push_back(8'd3);
        enq_pulse(8'd3);
        wait_busy(1'b1, 10, "mid_busy");
        enq_pulse(8'd1);
        enq_pulse(8'd2);
        check("mid_count", 32'(queue_count), 32'd2);
        mon_en = 1'b0;
        @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(queue_count), 32'd0);
        check("mid_rst_pwm", 32'(pwm), 32'd0);
        check("mid_rst_full", 32'(queue_full), 32'd0);
        reset = 1'b0;
        check_widths("post_rst", NEUT, NEUT, NEUT, NEUT, NEUT);
        max_busy = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            if (busy) max_busy = 1;
        end
        check("post_rst_no_play", 32'(max_busy), 32'd0);
        check("post_rst_count", 32'(queue_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
